// File: rtl/dac_pair_scheduler.sv
// -----------------------------------------------------------------------------
// dac_pair_scheduler
//
// Frame scheduler in front of the dual-channel AD56x3 DAC driver. It buffers
// one sample per channel from two independent Avalon-ST sources. It divides
// the master clock down to the DAC frame rate. On each frame tick it emits a
// coherent A-then-B sample pair to the driver on back-to-back beats.
// When a channel has no fresh sample, the last value is repeated. Such
// repeats, and ticks that arrive while a pair is still in flight, are counted
// for status readout.
//
// Ports
//   clk          master clock
//   reset        asynchronous, active-high reset
//   enable       1 = frame tick generator runs
//   clearCnt     synchronous clear of both status counters (wins over increment)
//   aValid/aData/aRdy   channel A sample sink (one-entry buffer)
//   bValid/bData/bRdy   channel B sample sink (one-entry buffer)
//   asoValid/asoChannel/asoData/asoRdy  pair source towards the driver
//   frameDone    one-cycle pulse after the channel B handshake
//   underrunCnt  saturating count of repeated channel samples
//   lateCnt      saturating count of ticks dropped while a pair was busy
// -----------------------------------------------------------------------------
module dac_pair_scheduler #(
    parameter int DATA_WIDTH   = 14,
    parameter int TICK_DIVIDER = 250,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clearCnt,
    input  logic                  aValid,
    input  logic [DATA_WIDTH-1:0] aData,
    output logic                  aRdy,
    input  logic                  bValid,
    input  logic [DATA_WIDTH-1:0] bData,
    output logic                  bRdy,
    output logic                  asoValid,
    output logic                  asoChannel,
    output logic [DATA_WIDTH-1:0] asoData,
    input  logic                  asoRdy,
    output logic                  frameDone,
    output logic [CNT_WIDTH-1:0]  underrunCnt,
    output logic [CNT_WIDTH-1:0]  lateCnt
);

    localparam int TICK_W = (TICK_DIVIDER > 1) ? $clog2(TICK_DIVIDER) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIVIDER - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_A = 2'd1,
        SEND_B = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Frame tick generator
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt_reg;
    logic [TICK_W-1:0] tick_cnt_next;
    logic              tick;

    assign tick = enable && (tick_cnt_reg == TICK_LAST);

    always_comb begin
        tick_cnt_next = tick_cnt_reg + TICK_W'(1);
        if (!enable || tick) begin
            tick_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel one-entry buffers (index 0 = A, 1 = B)
    // ------------------------------------------------------------------
    logic                  capture;
    logic                  in_valid [2];
    logic [DATA_WIDTH-1:0] in_data  [2];
    logic                  full_reg [2];
    logic [DATA_WIDTH-1:0] hold_reg [2];
    logic [DATA_WIDTH-1:0] last_reg [2];
    logic [DATA_WIDTH-1:0] cap_data [2];
    logic                  underrun [2];

    assign in_valid[0] = aValid;
    assign in_valid[1] = bValid;
    assign in_data[0]  = aData;
    assign in_data[1]  = bData;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            // Buffered sample first, then a sample arriving on the tick
            // cycle itself (bypass), otherwise repeat the previous value.
            assign cap_data[gi] = full_reg[gi] ? hold_reg[gi] :
                                  in_valid[gi] ? in_data[gi]  : last_reg[gi];
            assign underrun[gi] = capture && !full_reg[gi] && !in_valid[gi];

            // last_reg doubles as the outgoing sample for this channel:
            // it is loaded at capture and stays put until the next one.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    full_reg[gi] <= 1'b0;
                    hold_reg[gi] <= '0;
                    last_reg[gi] <= '0;
                end else if (capture) begin
                    // A bypassed sample is consumed directly, so the
                    // buffer is left empty in every capture case.
                    full_reg[gi] <= 1'b0;
                    last_reg[gi] <= cap_data[gi];
                end else if (in_valid[gi] && !full_reg[gi]) begin
                    full_reg[gi] <= 1'b1;
                    hold_reg[gi] <= in_data[gi];
                end
            end
        end
    endgenerate

    assign aRdy = !full_reg[0];
    assign bRdy = !full_reg[1];

    // ------------------------------------------------------------------
    // Pair FSM with registered outputs
    // ------------------------------------------------------------------
    state_t                state_reg;
    state_t                state_next;
    logic                  aso_valid_reg;
    logic                  aso_valid_next;
    logic                  aso_channel_reg;
    logic                  aso_channel_next;
    logic [DATA_WIDTH-1:0] aso_data_reg;
    logic [DATA_WIDTH-1:0] aso_data_next;
    logic                  frame_done_reg;
    logic                  frame_done_next;
    logic                  late;

    always_comb begin
        state_next       = state_reg;
        aso_valid_next   = aso_valid_reg;
        aso_channel_next = aso_channel_reg;
        aso_data_next    = aso_data_reg;
        frame_done_next  = 1'b0;
        capture          = 1'b0;
        late             = 1'b0;
        case (state_reg)
            IDLE: begin
                aso_valid_next = 1'b0;
                if (tick) begin
                    capture          = 1'b1;
                    state_next       = SEND_A;
                    aso_valid_next   = 1'b1;
                    aso_channel_next = 1'b0;
                    aso_data_next    = cap_data[0];
                end
            end
            SEND_A: begin
                late = tick;
                if (asoRdy) begin
                    // B follows immediately: the driver drops a lone A
                    // sample at its next sclk edge.
                    state_next       = SEND_B;
                    aso_channel_next = 1'b1;
                    aso_data_next    = last_reg[1];
                end
            end
            SEND_B: begin
                late = tick;
                if (asoRdy) begin
                    state_next      = IDLE;
                    aso_valid_next  = 1'b0;
                    frame_done_next = 1'b1;
                end
            end
            default: begin
                state_next     = IDLE;
                aso_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            aso_valid_reg   <= 1'b0;
            aso_channel_reg <= 1'b0;
            aso_data_reg    <= '0;
            frame_done_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            aso_valid_reg   <= aso_valid_next;
            aso_channel_reg <= aso_channel_next;
            aso_data_reg    <= aso_data_next;
            frame_done_reg  <= frame_done_next;
        end
    end

    assign asoValid   = aso_valid_reg;
    assign asoChannel = aso_channel_reg;
    assign asoData    = aso_data_reg;
    assign frameDone  = frame_done_reg;

    // ------------------------------------------------------------------
    // Saturating status counters
    // ------------------------------------------------------------------
    function automatic logic [CNT_WIDTH-1:0] sat_add(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic [1:0]           inc
    );
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, cnt} + (CNT_WIDTH + 1)'(inc);
        return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    endfunction

    logic [CNT_WIDTH-1:0] underrun_cnt_reg;
    logic [CNT_WIDTH-1:0] late_cnt_reg;
    logic [1:0]           underrun_inc;

    // Both channels can underrun on the same tick.
    assign underrun_inc = {1'b0, underrun[0]} + {1'b0, underrun[1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_cnt_reg <= '0;
            late_cnt_reg     <= '0;
        end else if (clearCnt) begin
            underrun_cnt_reg <= '0;
            late_cnt_reg     <= '0;
        end else begin
            underrun_cnt_reg <= sat_add(underrun_cnt_reg, underrun_inc);
            late_cnt_reg     <= sat_add(late_cnt_reg, {1'b0, late});
        end
    end

    assign underrunCnt = underrun_cnt_reg;
    assign lateCnt     = late_cnt_reg;

endmodule

// File: tb/tb_dac_pair_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dac_pair_scheduler
//
// Directed bench for dac_pair_scheduler with TICK_DIVIDER=8, CNT_WIDTH=2.
// The main process drives stimulus on a posedge-relative cycle index p
// (p=0 is the edge at which enable was raised, so capture edges are
// p=8,16,...). Expected driver beats are queued as they are planned. A
// separate monitor pops and compares them on each handshake, and checks
// that a stalled beat is held stable.
// -----------------------------------------------------------------------------
module tb_dac_pair_scheduler;

    localparam int DW = 14;
    localparam int TD = 8;
    localparam int CW = 2;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          enable   = 1'b0;
    logic          clearCnt = 1'b0;
    logic          aValid   = 1'b0;
    logic [DW-1:0] aData    = '0;
    logic          aRdy;
    logic          bValid   = 1'b0;
    logic [DW-1:0] bData    = '0;
    logic          bRdy;
    logic          asoValid;
    logic          asoChannel;
    logic [DW-1:0] asoData;
    logic          asoRdy   = 1'b1;
    logic          frameDone;
    logic [CW-1:0] underrunCnt;
    logic [CW-1:0] lateCnt;

    dac_pair_scheduler #(
        .DATA_WIDTH  (DW),
        .TICK_DIVIDER(TD),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .clearCnt   (clearCnt),
        .aValid     (aValid),
        .aData      (aData),
        .aRdy       (aRdy),
        .bValid     (bValid),
        .bData      (bData),
        .bRdy       (bRdy),
        .asoValid   (asoValid),
        .asoChannel (asoChannel),
        .asoData    (asoData),
        .asoRdy     (asoRdy),
        .frameDone  (frameDone),
        .underrunCnt(underrunCnt),
        .lateCnt    (lateCnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int p        = 0;
    int fd_count = 0;
    logic [DW:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (p=%0d)", name, act, exp, p);
        end
    endtask

    function automatic logic [DW:0] beat(input logic ch, input logic [DW-1:0] d);
        return {ch, d};
    endfunction

    task automatic push_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_q.push_back(beat(1'b0, a));
        exp_q.push_back(beat(1'b1, b));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        p++;
    endtask

    task automatic step_to(input int n);
        while (p < n) step();
    endtask

    // Scoreboard monitor: one line per completed beat.
    initial begin : monitor
        logic        prev_valid;
        logic        prev_rdy;
        logic [DW:0] prev_beat;
        logic [DW:0] e;
        prev_valid = 1'b0;
        prev_rdy   = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_valid = 1'b0;
            end else begin
                if (frameDone === 1'b1) fd_count++;
                if (prev_valid && !prev_rdy) begin
                    chk("stall_valid_held", 32'(asoValid), 32'd1);
                    chk("stall_beat_stable", 32'({asoChannel, asoData}), 32'(prev_beat));
                end
                if (asoValid === 1'b1 && asoRdy === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got ch%0d 0x%0h, expected no beat", asoChannel, asoData);
                    end else begin
                        e = exp_q.pop_front();
                        $display("beat p=%0d ch%0d data=0x%0h expected ch%0d 0x%0h",
                                 p, asoChannel, asoData, e[DW], e[DW-1:0]);
                        chk("beat", 32'({asoChannel, asoData}), 32'(e));
                    end
                end
                prev_valid = asoValid;
                prev_rdy   = asoRdy;
                prev_beat  = {asoChannel, asoData};
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        // Reset state
        step();
        step();
        chk("rst_aRdy", 32'(aRdy), 32'd1);
        chk("rst_bRdy", 32'(bRdy), 32'd1);
        chk("rst_asoValid", 32'(asoValid), 32'd0);
        chk("rst_asoChannel", 32'(asoChannel), 32'd0);
        chk("rst_asoData", 32'(asoData), 32'd0);
        chk("rst_frameDone", 32'(frameDone), 32'd0);
        chk("rst_underrunCnt", 32'(underrunCnt), 32'd0);
        chk("rst_lateCnt", 32'(lateCnt), 32'd0);
        reset = 1'b0;
        step();

        // 1: preload both buffers, then one full pair
        aValid = 1'b1; aData = 14'h0123;
        bValid = 1'b1; bData = 14'h3ABC;
        step();
        aValid = 1'b0; bValid = 1'b0;
        chk("s1_aRdy_full", 32'(aRdy), 32'd0);
        chk("s1_bRdy_full", 32'(bRdy), 32'd0);
        push_pair(14'h0123, 14'h3ABC);
        enable = 1'b1;
        p = 0;
        step_to(7);
        chk("s1_no_valid_before_tick", 32'(asoValid), 32'd0);
        step_to(8);
        chk("s1_valid_after_tick", 32'(asoValid), 32'd1);
        chk("s1_first_channel", 32'(asoChannel), 32'd0);
        chk("s1_aRdy_back", 32'(aRdy), 32'd1);
        chk("s1_bRdy_back", 32'(bRdy), 32'd1);
        step_to(9);
        chk("s1_b_beat_valid", 32'(asoValid), 32'd1);
        chk("s1_b_channel", 32'(asoChannel), 32'd1);
        step_to(10);
        chk("s1_frameDone", 32'(frameDone), 32'd1);
        chk("s1_valid_drop", 32'(asoValid), 32'd0);
        step_to(11);
        chk("s1_frameDone_pulse", 32'(frameDone), 32'd0);

        // 2: no new samples, pair repeated, both channels underrun
        push_pair(14'h0123, 14'h3ABC);
        step_to(15);
        chk("s2_underrun_before", 32'(underrunCnt), 32'd0);
        step_to(16);
        chk("s2_underrun_two", 32'(underrunCnt), 32'd2);

        // 3: driver stalls across a tick
        step_to(19);
        aValid = 1'b1; aData = 14'h0AAA;
        bValid = 1'b1; bData = 14'h1BBB;
        step();
        aValid = 1'b0; bValid = 1'b0;
        push_pair(14'h0AAA, 14'h1BBB);
        step_to(23);
        asoRdy = 1'b0;
        step_to(24);
        chk("s3_valid_stalled", 32'(asoValid), 32'd1);
        step_to(25);
        aValid = 1'b1; aData = 14'h0CCC;
        step();
        aValid = 1'b0;
        chk("s3_a_buffer_full", 32'(aRdy), 32'd0);
        step_to(31);
        chk("s3_late_before", 32'(lateCnt), 32'd0);
        step_to(32);
        chk("s3_late_one", 32'(lateCnt), 32'd1);
        chk("s3_no_capture", 32'(aRdy), 32'd0);
        chk("s3_a_data_held", 32'(asoData), 32'h0AAA);
        step_to(33);
        asoRdy = 1'b1;
        step_to(36);
        chk("s3_pair_done", 32'(asoValid), 32'd0);
        push_pair(14'h0CCC, 14'h1BBB);
        step_to(40);
        chk("s3_b_underrun", 32'(underrunCnt), 32'd3);
        chk("s3_a_consumed", 32'(aRdy), 32'd1);
        step_to(41);
        clearCnt = 1'b1;
        step();
        clearCnt = 1'b0;
        chk("clr_underrun", 32'(underrunCnt), 32'd0);
        chk("clr_late", 32'(lateCnt), 32'd0);

        // 4: channel A bypass on the tick cycle
        bValid = 1'b1; bData = 14'h2222;
        step();
        bValid = 1'b0;
        push_pair(14'h0555, 14'h2222);
        step_to(47);
        chk("s4_a_empty", 32'(aRdy), 32'd1);
        aValid = 1'b1; aData = 14'h0555;
        step();
        aValid = 1'b0;
        chk("s4_no_underrun", 32'(underrunCnt), 32'd0);
        chk("s4_a_still_empty", 32'(aRdy), 32'd1);
        chk("s4_bypass_data", 32'(asoData), 32'h0555);

        // 5: saturation, then clear on an underrun tick
        push_pair(14'h0555, 14'h2222);
        push_pair(14'h0555, 14'h2222);
        push_pair(14'h0555, 14'h2222);
        push_pair(14'h0555, 14'h2222);
        step_to(56);
        chk("s5_underrun_2", 32'(underrunCnt), 32'd2);
        step_to(64);
        chk("s5_underrun_sat", 32'(underrunCnt), 32'd3);
        step_to(71);
        chk("s5_sat_hold", 32'(underrunCnt), 32'd3);
        step_to(72);
        chk("s5_sat_hold_tick", 32'(underrunCnt), 32'd3);
        step_to(79);
        clearCnt = 1'b1;
        step();
        clearCnt = 1'b0;
        chk("s5_clear_wins", 32'(underrunCnt), 32'd0);

        // 6: reset during SEND_B
        exp_q.push_back(beat(1'b0, 14'h0555));
        step_to(89);
        chk("s6_in_send_b", 32'({asoValid, asoChannel}), 32'd3);
        reset = 1'b1;
        #1;
        chk("s6_async_valid", 32'(asoValid), 32'd0);
        chk("s6_async_channel", 32'(asoChannel), 32'd0);
        chk("s6_async_data", 32'(asoData), 32'd0);
        chk("s6_async_underrun", 32'(underrunCnt), 32'd0);
        enable = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        push_pair(14'h0000, 14'h0000);
        enable = 1'b1;
        p = 0;
        step_to(7);
        chk("s6_no_early_tick", 32'(asoValid), 32'd0);
        step_to(8);
        chk("s6_tick_after_div", 32'(asoValid), 32'd1);
        chk("s6_last_cleared_underrun", 32'(underrunCnt), 32'd2);
        step_to(12);
        chk("frameDone_count", 32'(fd_count), 32'd10);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_pair_scheduler.md
Name: dac_pair_scheduler

Overview:
Sample-frame scheduler that sits in front of the dual-channel AD56x3 DAC driver. It buffers one sample per channel from two independent upstream Avalon-ST sources and generates the DAC frame rate from the master clock. On each frame tick it presents a coherent A-then-B sample pair to the driver's single sink, on back-to-back handshakes. It repeats the last sample on underrun and counts underruns and late (dropped) ticks for status readout.

Parameters:
DATA_WIDTH, 14, sample width; must match the driver.
TICK_DIVIDER, 250, clk cycles per frame; must be >= 4, and >= the driver's pair transfer time.
CNT_WIDTH, 16, width of the status counters.

Ports:
clk  in  1  master clock
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = frame tick generator runs
clearCnt  in  1  synchronous clear of both status counters
aValid  in  1  channel A sample valid
aData  in  DATA_WIDTH  channel A sample
aRdy  out  1  channel A buffer can accept
bValid  in  1  channel B sample valid
bData  in  DATA_WIDTH  channel B sample
bRdy  out  1  channel B buffer can accept
asoValid  out  1  to driver asiValid
asoChannel  out  1  to driver asiChannel (0 = A, 1 = B)
asoData  out  DATA_WIDTH  to driver asiData
asoRdy  in  1  from driver asiRdy
frameDone  out  1  1-cycle pulse on channel B handshake
underrunCnt  out  CNT_WIDTH  saturating count of channel samples repeated
lateCnt  out  CNT_WIDTH  saturating count of ticks dropped while busy

Behaviour:
- Reset values: aRdy=1, bRdy=1, asoValid=0, asoChannel=0, asoData=0, frameDone=0, underrunCnt=0, lateCnt=0. Also: tickCnt=0, holding buffers empty, lastA=lastB=0, state=IDLE.
- Per-channel one-entry buffer (A shown; B identical):
  - aRdy = ~fullA.
  - aValid & aRdy stores aData and sets fullA.
- Tick generator:
  - tickCnt counts 0..TICK_DIVIDER-1 while enable=1, then wraps to 0.
  - tick = 1 on the cycle tickCnt == TICK_DIVIDER-1.
  - enable=0 holds tickCnt at 0 and produces no ticks. A pair already in progress still completes.
- Pair capture happens on the tick cycle when state == IDLE:
  - If fullA: outA <= holdA, fullA cleared.
  - Else if aValid is high this cycle: outA <= aData (bypass). Buffer stays empty; no underrun.
  - Else: outA <= lastA, and underrunCnt increments by 1.
  - lastA <= outA value. Same rules for B.
  - If both channels underrun on the same tick, underrunCnt increments by 2.
- FSM:
  - IDLE: asoValid=0. On tick, capture the pair and go to SEND_A.
  - SEND_A: asoValid=1, asoChannel=0, asoData=outA. When asoRdy=1, go to SEND_B.
  - SEND_B: asoValid=1, asoChannel=1, asoData=outB. When asoRdy=1, pulse frameDone and go to IDLE.
- Outputs are registered. The B beat is driven on the cycle immediately after the A handshake, because the driver discards a lone A sample at its next sclk edge.
- asoValid is never deasserted before the handshake, and asoData/asoChannel stay stable while valid.
- A tick arriving in SEND_A or SEND_B is dropped: lateCnt increments by 1 and no capture occurs.
- Counters saturate at all-ones. clearCnt has priority over a same-cycle increment. Counters are independent of enable.
- Latency: tick -> asoValid(A) is 1 cycle. A handshake -> asoValid(B) is 1 cycle.
- Reset asserted mid-pair: outputs return to reset values immediately. The partial pair is abandoned, and the driver's own reset recovers it.

Test Plan:
1. TICK_DIVIDER=8, enable=1. Preload A=0x0123, B=0x3ABC; hold asoRdy=1. Required:
   - asoValid rises 1 cycle after the tick.
   - Beats (ch0, 0x0123) then (ch1, 0x3ABC) on consecutive cycles.
   - frameDone pulses once; aRdy and bRdy return to 1.
2. No new samples after scenario 1; next tick. Required: pair 0x0123/0x3ABC is repeated and underrunCnt=2.
3. Hold asoRdy=0 for 10 cycles across the next tick boundary. Required:
   - The A beat is held stable with asoValid=1.
   - The tick arriving during SEND_A increments lateCnt to 1 and captures nothing.
   - After asoRdy=1, the pair completes normally.
4. aValid pulses with aData=0x0555 exactly on the tick cycle while the A buffer is empty. Required: the A beat carries 0x0555, underrunCnt is unchanged, and fullA stays 0.
5. Force underrunCnt to all-ones via repeated underruns (CNT_WIDTH=2), then assert clearCnt on the same cycle as another underrun. Required:
   - The counter holds at 3 while saturated.
   - It reads 0 after the clear cycle.
6. Assert reset during SEND_B. Required:
   - asoValid=0 in the same cycle (asynchronous).
   - After release: state IDLE, lastA=lastB=0, and the first tick arrives TICK_DIVIDER cycles after enable.
